// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit: pipelined multiplier plus radix-2 serial divider
// sharing one tagged writeback port. A multiplier result always wins the port.
module muldiv_unit #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned MUL_LATENCY   = 2,
    parameter int unsigned TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [3:0]               op_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o
);

    localparam int unsigned CntW  = $clog2(XLEN + 1);
    localparam int unsigned ProdW = 2 * XLEN + 2;
    localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StIter, StDone} div_state_e;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        return XLEN'(s);
    endfunction

    // ---------------------------------------------------------------- decode
    logic op_is_mul, op_is_div;
    logic div_idle, mul_accept, div_accept;

    assign op_is_mul  = (op_i[3:2] == 2'b00) | (op_i == 4'd8);
    assign op_is_div  = op_i[2];
    assign ready_o    = div_idle | op_is_mul;
    assign mul_accept = valid_i & ~flush_i & op_is_mul;
    assign div_accept = valid_i & ~flush_i & op_is_div & div_idle;

    // ------------------------------------------------------------ multiplier
    logic                     mul_a_signed, mul_b_signed;
    logic signed [XLEN:0]     mul_a, mul_b;
    logic signed [ProdW-1:0]  mul_prod;
    logic [XLEN-1:0]          mul_result;
    logic                     unused_prod;

    assign mul_a_signed = (op_i == 4'd1) | (op_i == 4'd2);
    assign mul_b_signed = (op_i == 4'd1);
    assign mul_a        = {mul_a_signed & operand_a_i[XLEN-1], operand_a_i};
    assign mul_b        = {mul_b_signed & operand_b_i[XLEN-1], operand_b_i};
    assign mul_prod     = ProdW'(mul_a) * ProdW'(mul_b);
    assign unused_prod  = ^mul_prod[ProdW-1:2*XLEN];

    always_comb begin
        mul_result = mul_prod[2*XLEN-1:XLEN];
        if (op_i == 4'd0) begin
            mul_result = mul_prod[XLEN-1:0];
        end else if (op_i == 4'd8) begin
            mul_result = sext32(mul_prod[31:0]);
        end
    end

    logic [MUL_LATENCY-1:0]   mul_valid_q;
    logic [XLEN-1:0]          mul_res_q [MUL_LATENCY];
    logic [TRANS_ID_BITS-1:0] mul_id_q  [MUL_LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mul_valid_q <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                mul_res_q[i] <= '0;
                mul_id_q[i]  <= '0;
            end
        end else begin
            mul_valid_q[0] <= mul_accept;
            mul_res_q[0]   <= mul_result;
            mul_id_q[0]    <= trans_id_i;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                mul_valid_q[i] <= mul_valid_q[i-1];
                mul_res_q[i]   <= mul_res_q[i-1];
                mul_id_q[i]    <= mul_id_q[i-1];
            end
            if (flush_i) begin
                mul_valid_q <= '0;
            end
        end
    end

    // --------------------------------------------------------------- divider
    logic            div_word, div_signed, sign_a, sign_b;
    logic [XLEN-1:0] div_a, div_b, abs_a, abs_b, fast_sel, fast_res;
    logic            b_zero, ovf;

    assign div_word   = op_i[3];
    assign div_signed = ~op_i[0];

    always_comb begin
        div_a = operand_a_i;
        div_b = operand_b_i;
        if (div_word) begin
            div_a = div_signed ? sext32(operand_a_i[31:0]) : XLEN'(operand_a_i[31:0]);
            div_b = div_signed ? sext32(operand_b_i[31:0]) : XLEN'(operand_b_i[31:0]);
        end
    end

    assign sign_a   = div_signed & div_a[XLEN-1];
    assign sign_b   = div_signed & div_b[XLEN-1];
    assign abs_a    = sign_a ? -div_a : div_a;
    assign abs_b    = sign_b ? -div_b : div_b;
    assign b_zero   = (div_b == '0);
    assign ovf      = div_signed & (div_b == '1) &
                      (div_word ? (operand_a_i[31:0] == 32'h8000_0000) : (div_a == MostNeg));
    assign fast_sel = op_i[1] ? (b_zero ? div_a : '0) : (b_zero ? '1 : div_a);
    assign fast_res = div_word ? sext32(fast_sel[31:0]) : fast_sel;

    div_state_e               state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [XLEN-1:0]          rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
    logic [XLEN-1:0]          result_q, result_d;
    logic [TRANS_ID_BITS-1:0] div_id_q, div_id_d;
    logic                     is_rem_q, is_rem_d, is_word_q, is_word_d;
    logic                     quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

    // One restoring step: shift the next dividend bit into the partial remainder.
    logic [XLEN:0]   shifted, diff;
    logic            step_ge;
    logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix, final_sel, final_res;

    assign shifted   = {rem_q, quo_q[XLEN-1]};
    assign diff      = shifted - {1'b0, divisor_q};
    assign step_ge   = ~diff[XLEN];
    assign rem_nxt   = step_ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nxt   = {quo_q[XLEN-2:0], step_ge};
    assign quo_fix   = quo_neg_q ? -quo_nxt : quo_nxt;
    assign rem_fix   = rem_neg_q ? -rem_nxt : rem_nxt;
    assign final_sel = is_rem_q ? rem_fix : quo_fix;
    assign final_res = is_word_q ? sext32(final_sel[31:0]) : final_sel;

    logic mul_out_valid, div_grant;

    assign div_idle      = (state_q == StIdle);
    assign mul_out_valid = mul_valid_q[MUL_LATENCY-1];
    assign div_grant     = (state_q == StDone) & ~mul_out_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        div_id_d  = div_id_q;
        is_rem_d  = is_rem_q;
        is_word_d = is_word_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        unique case (state_q)
            StIdle: begin
                if (div_accept) begin
                    div_id_d  = trans_id_i;
                    is_rem_d  = op_i[1];
                    is_word_d = div_word;
                    quo_neg_d = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    divisor_d = abs_b;
                    rem_d     = '0;
                    // Word dividends start at the top so 32 steps consume them fully.
                    quo_d     = div_word ? (abs_a << (XLEN - 32)) : abs_a;
                    cnt_d     = div_word ? CntW'(32) : CntW'(XLEN);
                    if (b_zero | ovf) begin
                        result_d = fast_res;
                        state_d  = StDone;
                    end else begin
                        state_d = StIter;
                    end
                end
            end
            StIter: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    result_d = final_res;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (div_grant) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            result_q  <= '0;
            div_id_q  <= '0;
            is_rem_q  <= 1'b0;
            is_word_q <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
            div_id_q  <= div_id_d;
            is_rem_q  <= is_rem_d;
            is_word_q <= is_word_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    // ------------------------------------------------------------- writeback
    assign valid_o    = mul_out_valid | div_grant;
    assign result_o   = mul_out_valid ? mul_res_q[MUL_LATENCY-1] :
                        (div_grant ? result_q : '0);
    assign trans_id_o = mul_out_valid ? mul_id_q[MUL_LATENCY-1] :
                        (div_grant ? div_id_q : '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=64, MUL_LATENCY=2): directed corner cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_ni, flush_i, valid_i, ready_o, valid_o;
    logic [3:0]  op_i;
    logic [63:0] a, b, result_o;
    logic [2:0]  id, trans_id_o;

    int n_tests;
    int n_fail;

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN          (64),
        .MUL_LATENCY   (2),
        .TRANS_ID_BITS (3)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .op_i        (op_i),
        .operand_a_i (a),
        .operand_b_i (b),
        .trans_id_i  (id),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .result_o    (result_o),
        .trans_id_o  (trans_id_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op <= 4'd3) || (op == 4'd8);
    endfunction

    function automatic logic is_fast(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        logic sgn;
        sgn = ~op[0];
        if (op[3]) return (y[31:0] == 32'd0) ||
                          (sgn && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF);
        return (y == 64'd0) || (sgn && x == MIN64 && y == ONES);
    endfunction

    function automatic int lat_of(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        if (is_mul(op)) return 2;
        if (is_fast(op, x, y)) return 1;
        return op[3] ? 33 : 65;
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] x,
                                          input logic [63:0] y);
        logic signed [127:0] ps;
        logic [127:0]        pu;
        logic [63:0]         q, r;
        logic [31:0]         x32, y32, q32, r32;
        logic                sgn;
        sgn = ~op[0];
        x32 = x[31:0];
        y32 = y[31:0];
        case (op)
            4'd0: return x * y;
            4'd1: begin
                ps = 128'($signed(x)) * 128'($signed(y));
                return ps[127:64];
            end
            4'd2: begin
                ps = $signed({{64{x[63]}}, x}) * $signed({64'd0, y});
                return ps[127:64];
            end
            4'd3: begin
                pu = {64'd0, x} * {64'd0, y};
                return pu[127:64];
            end
            4'd8: begin
                q32 = x32 * y32;
                return sx32(q32);
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
                if (y == 64'd0) begin
                    q = ONES;
                    r = x;
                end else if (sgn && x == MIN64 && y == ONES) begin
                    q = x;
                    r = 64'd0;
                end else if (sgn) begin
                    q = 64'($signed(x) / $signed(y));
                    r = 64'($signed(x) % $signed(y));
                end else begin
                    q = x / y;
                    r = x % y;
                end
                return op[1] ? r : q;
            end
            default: begin
                if (y32 == 32'd0) begin
                    q32 = 32'hFFFF_FFFF;
                    r32 = x32;
                end else if (sgn && x32 == 32'h8000_0000 && y32 == 32'hFFFF_FFFF) begin
                    q32 = x32;
                    r32 = 32'd0;
                end else if (sgn) begin
                    q32 = 32'($signed(x32) / $signed(y32));
                    r32 = 32'($signed(x32) % $signed(y32));
                end else begin
                    q32 = x32 / y32;
                    r32 = x32 % y32;
                end
                return sx32(op[1] ? r32 : q32);
            end
        endcase
    endfunction

    function automatic logic [63:0] rand_opnd();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 20));
            2:       return ONES;
            3:       return MIN64;
            4:       return {{32{r[31]}}, r};
            default: return 64'd0 - 64'($urandom_range(1, 100));
        endcase
    endfunction

    // Issue one op in the current cycle and wait for its tagged result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] oa,
                          input logic [63:0] ob, input logic [2:0] tid,
                          output logic [63:0] got_res);
        int          lat, k;
        bit          got;
        logic [63:0] exp;
        exp = model(op, oa, ob);
        lat = lat_of(op, oa, ob);
        valid_i = 1'b1;
        op_i    = op;
        a       = oa;
        b       = ob;
        id      = tid;
        @(negedge clk);
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        check({tag, "_idle_out"}, 64'(valid_o), 64'd0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        k   = 1;
        got = 1'b0;
        while (!got && k <= lat + 4) begin
            @(negedge clk);
            if (valid_o) got = 1'b1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        got_res = result_o;
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_result"}, result_o, exp);
        check({tag, "_id"}, 64'(trans_id_o), 64'(tid));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_strobe"}, 64'(valid_o), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res, ma, mb, mexp;
        logic [63:0] bb_a [3];
        logic [63:0] bb_b [3];
        logic [3:0]  bb_op [3];
        logic [3:0]  legal_ops [13];
        logic [3:0]  rop;
        int          seen;

        n_tests = 0;
        n_fail  = 0;
        bb_op     = '{4'd0, 4'd1, 4'd8};
        legal_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                      4'd12, 4'd13, 4'd14, 4'd15};

        // Reset state
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        op_i = 4'd4; a = '0; b = '0; id = '0;
        #3;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", result_o, 64'd0);
        check("rst_id", 64'(trans_id_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Directed multiply / divide corners
        run_op("mulhu", 4'd3, ONES, 64'd2, 3'd5, res);
        check("mulhu_const", res, 64'd1);
        run_op("div_m7_2", 4'd4, 64'd0 - 64'd7, 64'd2, 3'd1, res);
        check("div_const", res, 64'd0 - 64'd3);
        run_op("rem_m7_2", 4'd6, 64'd0 - 64'd7, 64'd2, 3'd2, res);
        check("rem_const", res, ONES);
        run_op("divuw", 4'd13, 64'h1_0000_0010, 64'd3, 3'd3, res);
        check("divuw_const", res, 64'd5);
        run_op("divu_by0", 4'd5, 64'h1234_5678_9ABC_DEF0, 64'd0, 3'd4, res);
        check("divu_by0_const", res, ONES);
        run_op("rem_ovf", 4'd6, MIN64, ONES, 3'd6, res);
        check("rem_ovf_const", res, 64'd0);
        run_op("divw_ovf", 4'd12, 64'h8000_0000, 64'hFFFF_FFFF, 3'd7, res);
        check("divw_ovf_const", res, 64'hFFFF_FFFF_8000_0000);
        run_op("remuw_by0", 4'd15, 64'h0000_0001_8000_0001, 64'h0000_0005_0000_0000, 3'd0, res);

        // Three back-to-back multiplies return on consecutive cycles
        for (int i = 0; i < 3; i++) begin
            bb_a[i] = rand_opnd();
            bb_b[i] = rand_opnd();
        end
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                valid_i = 1'b1; op_i = bb_op[c]; a = bb_a[c]; b = bb_b[c]; id = 3'(c + 1);
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
            if (c >= 2) begin
                check($sformatf("b2b%0d_valid", c - 2), 64'(valid_o), 64'd1);
                check($sformatf("b2b%0d_result", c - 2), result_o,
                      model(bb_op[c-2], bb_a[c-2], bb_b[c-2]));
                check($sformatf("b2b%0d_id", c - 2), 64'(trans_id_o), 64'(c - 1));
            end
            @(posedge clk); #1;
        end

        // Illegal opcode is never accepted
        valid_i = 1'b1; op_i = 4'd9; a = 64'd3; b = 64'd4; id = 3'd1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (valid_o) seen++;
            @(posedge clk); #1;
        end
        check("illegal_no_result", 64'(seen), 64'd0);

        // Collision: MUL at c-2 (id 2), fast divide at c-1 completing in c
        ma = rand_opnd(); mb = rand_opnd();
        mexp = model(4'd0, ma, mb);
        valid_i = 1'b1; op_i = 4'd0; a = ma; b = mb; id = 3'd2;
        @(posedge clk); #1;
        op_i = 4'd5; a = 64'd123; b = 64'd0; id = 3'd6;
        @(negedge clk);
        check("coll_div_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        @(negedge clk);
        check("coll_c_valid", 64'(valid_o), 64'd1);
        check("coll_c_id", 64'(trans_id_o), 64'd2);
        check("coll_c_result", result_o, mexp);
        check("coll_c_ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("coll_c1_valid", 64'(valid_o), 64'd1);
        check("coll_c1_id", 64'(trans_id_o), 64'd6);
        check("coll_c1_result", result_o, ONES);
        check("coll_c1_ready", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("coll_c2_ready", 64'(ready_o), 64'd1);
        check("coll_c2_valid", 64'(valid_o), 64'd0);
        @(posedge clk); #1;

        // Flush mid-ITER at t+10 with one MUL in flight
        valid_i = 1'b1; op_i = 4'd4; a = 64'd1000; b = 64'd7; id = 3'd1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        valid_i = 1'b1; op_i = 4'd0; a = 64'd3; b = 64'd5; id = 3'd3;
        @(negedge clk);
        check("flush_mul_ready", 64'(ready_o), 64'd1);
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        check("flush_cycle_valid", 64'(valid_o), 64'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        run_op("post_flush_div", 4'd4, 64'd0 - 64'd100_003, 64'd17, 3'd4, res);

        // Asynchronous reset while the divider holds a result
        valid_i = 1'b1; op_i = 4'd5; a = 64'd55; b = 64'd0; id = 3'd7;
        @(posedge clk); #1;
        valid_i = 1'b0;
        #1;
        check("pre_rst_valid", 64'(valid_o), 64'd1);
        check("pre_rst_ready", 64'(ready_o), 64'd0);
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 64'(valid_o), 64'd0);
        check("async_rst_result", result_o, 64'd0);
        check("async_rst_id", 64'(trans_id_o), 64'd0);
        check("async_rst_ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_remu", 4'd7, 64'hDEAD_BEEF_0000_1234, 64'd1_000_003, 3'd5, res);

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = legal_ops[$urandom_range(0, 12)];
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, rand_opnd(), rand_opnd(),
                   3'($urandom_range(0, 7)), res);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised integer multiply/divide functional unit for the execute stage. It is the next-generation replacement for the fixed-width multiply/divide wrapper. It contains a configurable-depth pipelined multiplier and an embedded radix-2 serial divider, and merges both onto a single writeback port tagged with a transaction ID. Beyond the previous unit, it adds configurable multiplier latency, a divider fast path for divide-by-zero and signed overflow, early termination for 32-bit word divides, and parametrised XLEN.

## Interface
- XLEN, 64: datapath width, 32 or 64.
- MUL_LATENCY, 2: multiplier pipeline depth in cycles, must be ≥1.
- TRANS_ID_BITS, 3: transaction ID width.

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  kill all in-flight operations, block issue this cycle
- valid_i  in  1  operation request
- op_i  in  4  opcode:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW
  - 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW
  - all other codes are ignored (never accepted)
- operand_a_i  in  XLEN  rs1
- operand_b_i  in  XLEN  rs2
- trans_id_i  in  TRANS_ID_BITS  tag of the request
- ready_o  out  1  request acceptable; combinational, = div_idle | op_is_mul
- valid_o  out  1  result valid (single-cycle strobe, no backpressure)
- result_o  out  XLEN  result
- trans_id_o  out  TRANS_ID_BITS  tag of the result

## Operation
- Accept = valid_i & ready_o & ~flush_i & legal opcode.
- When XLEN=32, word opcodes behave exactly as their non-word counterparts.
- Multiplier: MUL_LATENCY-deep valid/tag/result pipeline, accepts every cycle.
  - MUL returns low XLEN bits of the product.
  - MULH returns high XLEN bits of signed×signed.
  - MULHSU returns high XLEN bits of signed a × unsigned b.
  - MULHU returns high XLEN bits of unsigned×unsigned.
  - MULW returns sext32 of the low 32 bits of a[31:0]×b[31:0].
- Divider FSM states:
  - IDLE: div_idle=1. On a divide accept, latch tag, opcode and |a|,|b| (signed ops) or raw values. Word ops take operand[31:0], sign- or zero-extended per signedness. Load the iteration counter with 32 for word ops, else XLEN.
    - If b==0 or (signed & a==most-negative & b==−1), go to DONE (fast path).
    - Otherwise go to ITER.
  - ITER: one restoring-division step per cycle, decrementing the counter. The step taken when the counter reaches 1 also applies sign correction and registers the final result, then transitions to DONE.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
  - DONE: presents the result. When the output is granted, go to IDLE at the next edge; otherwise hold.
- Fast-path results:
  - Divide by zero: quotient = all ones, remainder = dividend (word: the 32-bit dividend).
  - Overflow: quotient = dividend, remainder = 0.
- Word divide results are sext32 of the 32-bit result.
- Output arbitration: a multiplier result has absolute priority. The divider result is granted only in a DONE cycle with no multiplier result at the pipeline output. valid_o = mul_out_valid | (DONE & ~mul_out_valid).
- Flush:
  - Clears all multiplier stage valids and forces the divider to IDLE at the next edge, from any state including mid-ITER and DONE.
  - A result presented in the flush cycle itself is still driven (valid_o is not masked combinationally).
- Reset: divider IDLE, all pipeline valids 0, valid_o=0, result_o=0, trans_id_o=0, ready_o=1.

## Timing
- Multiply accepted in cycle t → valid_o in cycle t+MUL_LATENCY. Sustained throughput is 1 per cycle.
- Divide accepted in cycle t:
  - Normal: valid_o in cycle t+N+1 (N = 32 or XLEN) if not blocked.
  - Fast path: valid_o in t+1.
  - Each cycle of multiplier collision delays it by 1.
- ready_o for divides returns to 1 in the cycle after the divider result is granted. A new divide cannot be accepted in the grant cycle.
- Multiply issue does not depend on divider state.

## Test plan
- XLEN=64, MUL_LATENCY=2: MULHU a=0xFFFF_FFFF_FFFF_FFFF, b=2, id=5 at t=0 → valid_o at t=2, result 1, trans_id_o 5; also three back-to-back MULs return results on 3 consecutive cycles.
- DIV a=−7, b=2 → result −3 at t+65. REM with the same operands → −1. DIVUW a=0x1_0000_0010, b=3 → 5 at t+33.
- DIVU b=0 → all ones at t+1. REM a=0x8000…0000, b=−1 → 0 at t+1. DIVW a=0x8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Collision: a divide completes in cycle c while a MUL (id 2) is accepted at c−2 → MUL result in c, divider result in c+1, ready_o=1 in c+2; no tag is lost.
- Flush mid-ITER (cycle t+10) with one MUL in the pipe → no valid_o for either, ready_o=1 in t+11, and a new DIV accepted at t+11 completes correctly.
- Reset asserted mid-divide → all outputs 0 and ready_o=1 immediately (asynchronously); operation resumes normally after release.
